// File: rtl/sa_pkg.sv
// Shared constants and state encoding for the systolic-array tile scheduler.
package sa_pkg;
  localparam int DW    = 16;
  localparam int FRAC  = 13;
  localparam int N_COL = 64;

  localparam logic [DW-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DW-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    WAIT,
    DONE
  } sa_sched_state_t;
endpackage

// File: rtl/sa_acc_lane.sv
// One Q2.13 accumulator lane: loads the first partial product, otherwise adds.
// SA_SCHED_SAT_EN selects a saturating add; the default build wraps.
module sa_acc_lane
  import sa_pkg::*;
(
  input  logic          i_load,
  input  logic [DW-1:0] i_acc,
  input  logic [DW-1:0] i_val,
  output logic [DW-1:0] o_sum
);

  logic [DW-1:0] w_add;

  assign w_add = i_acc + i_val;

`ifdef SA_SCHED_SAT_EN
  logic w_ovf;

  // Overflow only when both operands share a sign and the result flips it.
  assign w_ovf = (i_acc[DW-1] == i_val[DW-1]) && (w_add[DW-1] != i_acc[DW-1]);

  always_comb begin
    o_sum = w_add;
    if (i_load) begin
      o_sum = i_val;
    end else if (w_ovf) begin
      o_sum = i_acc[DW-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign o_sum = i_load ? i_val : w_add;
`endif

endmodule

// File: rtl/sa_tile_sched.sv
// Tile scheduler: fetches X/W tiles by index, fires the array once per tile, accumulates Q2.13 lanes.
// Lane add behaviour set by SA_SCHED_SAT_EN; result is held on O_RES until I_RES_RDY.
module sa_tile_sched
  import sa_pkg::*;
#(
  parameter int S    = 2,
  parameter int X_R  = 2,
  parameter int KT_W = 8
) (
  input  logic                      I_CLK,
  input  logic                      I_RST,
  input  logic                      I_JOB_VLD,
  output logic                      O_JOB_RDY,
  input  logic [KT_W-1:0]           I_JOB_KT,
  output logic                      O_FETCH_REQ,
  output logic [KT_W-1:0]           O_FETCH_IDX,
  input  logic                      I_FETCH_ACK,
  input  logic [S*X_R*DW-1:0]       I_FETCH_X,
  input  logic [S*N_COL*DW-1:0]     I_FETCH_W,
  output logic                      O_SA_START,
  output logic [S*X_R*DW-1:0]       O_SA_X,
  output logic [S*N_COL*DW-1:0]     O_SA_W,
  input  logic                      I_SA_OUT_VLD,
  input  logic [X_R*N_COL*DW-1:0]   I_SA_OUT,
  output logic                      O_RES_VLD,
  input  logic                      I_RES_RDY,
  output logic [X_R*N_COL*DW-1:0]   O_RES,
  output logic                      O_BUSY
);

  localparam int NL = X_R * N_COL;

  sa_sched_state_t         r_state;
  sa_sched_state_t         w_next;
  logic [KT_W-1:0]         r_kt;
  logic [KT_W-1:0]         r_idx;
  logic [KT_W-1:0]         w_idx_inc;
  logic [NL*DW-1:0]        r_acc;
  logic [NL*DW-1:0]        w_acc_nxt;
  logic [S*X_R*DW-1:0]     r_sa_x;
  logic [S*N_COL*DW-1:0]   r_sa_w;
  logic                    w_accept;
  logic                    w_fetch_done;
  logic                    w_tile_done;
  logic                    w_load;

  assign w_idx_inc = r_idx + 1'b1;
  assign w_load    = (r_idx == '0);

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_fetch_done = 1'b0;
    w_tile_done  = 1'b0;
    // Ready is masked by reset so the job side never sees an accept window during it.
    O_JOB_RDY    = (r_state == IDLE) && !I_RST;
    O_FETCH_REQ  = (r_state == FETCH);
    O_SA_START   = (r_state == START);
    O_RES_VLD    = (r_state == DONE);
    O_BUSY       = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (I_JOB_VLD) begin
          w_accept = 1'b1;
          w_next   = (I_JOB_KT == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (I_FETCH_ACK) begin
          w_fetch_done = 1'b1;
          w_next       = START;
        end
      end
      START: w_next = WAIT;
      WAIT: begin
        if (I_SA_OUT_VLD) begin
          w_tile_done = 1'b1;
          w_next      = (w_idx_inc == r_kt) ? DONE : FETCH;
        end
      end
      DONE: begin
        if (I_RES_RDY) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_kt   <= '0;
      r_idx  <= '0;
      r_acc  <= '0;
      r_sa_x <= '0;
      r_sa_w <= '0;
    end else begin
      if (w_accept) begin
        r_kt  <= I_JOB_KT;
        r_idx <= '0;
        r_acc <= '0;
      end
      // Tile registers are only rewritten on the next fetch, so they hold through WAIT.
      if (w_fetch_done) begin
        r_sa_x <= I_FETCH_X;
        r_sa_w <= I_FETCH_W;
      end
      if (w_tile_done) begin
        r_acc <= w_acc_nxt;
        r_idx <= w_idx_inc;
      end
    end
  end

  for (genvar g = 0; g < NL; g++) begin : g_lane
    sa_acc_lane u_lane (
      .i_load (w_load),
      .i_acc  (r_acc[g*DW +: DW]),
      .i_val  (I_SA_OUT[g*DW +: DW]),
      .o_sum  (w_acc_nxt[g*DW +: DW])
    );
  end

  assign O_FETCH_IDX = r_idx;
  assign O_SA_X      = r_sa_x;
  assign O_SA_W      = r_sa_w;
  assign O_RES       = r_acc;

endmodule

// File: tb/tb_sa_tile_sched.sv
// Directed bench for sa_tile_sched with a result scoreboard; honours SA_SCHED_SAT_EN.
module tb_sa_tile_sched;
  localparam int S    = 2;
  localparam int X_R  = 2;
  localparam int KT_W = 8;
  localparam int NL   = X_R * 64;
  localparam int XW   = S * X_R * 16;
  localparam int WW   = S * 64 * 16;
  localparam int RW   = NL * 16;

`ifdef SA_SCHED_SAT_EN
  localparam logic [15:0] EXP_POS = 16'h7FFF;
  localparam logic [15:0] EXP_NEG = 16'h8000;
`else
  localparam logic [15:0] EXP_POS = 16'hC000;
  localparam logic [15:0] EXP_NEG = 16'h4000;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            job_vld;
  logic            job_rdy;
  logic [KT_W-1:0] job_kt;
  logic            fetch_req;
  logic [KT_W-1:0] fetch_idx;
  logic            fetch_ack;
  logic [XW-1:0]   fetch_x;
  logic [WW-1:0]   fetch_w;
  logic            sa_start;
  logic [XW-1:0]   sa_x;
  logic [WW-1:0]   sa_w;
  logic            sa_out_vld;
  logic [RW-1:0]   sa_out;
  logic            res_vld;
  logic            res_rdy;
  logic [RW-1:0]   res;
  logic            busy;

  always #5 clk = ~clk;

  sa_tile_sched #(.S(S), .X_R(X_R), .KT_W(KT_W)) dut (
    .I_CLK        (clk),
    .I_RST        (rst),
    .I_JOB_VLD    (job_vld),
    .O_JOB_RDY    (job_rdy),
    .I_JOB_KT     (job_kt),
    .O_FETCH_REQ  (fetch_req),
    .O_FETCH_IDX  (fetch_idx),
    .I_FETCH_ACK  (fetch_ack),
    .I_FETCH_X    (fetch_x),
    .I_FETCH_W    (fetch_w),
    .O_SA_START   (sa_start),
    .O_SA_X       (sa_x),
    .O_SA_W       (sa_w),
    .I_SA_OUT_VLD (sa_out_vld),
    .I_SA_OUT     (sa_out),
    .O_RES_VLD    (res_vld),
    .I_RES_RDY    (res_rdy),
    .O_RES        (res),
    .O_BUSY       (busy)
  );

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_req = 0;
  logic [RW-1:0] exp_q[$];

  function automatic logic [RW-1:0] splat(input logic [15:0] v);
    logic [RW-1:0] r;
    for (int i = 0; i < NL; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every result handshake consumes one expected result.
  always @(negedge clk) begin
    if (sa_start) n_start++;
    if (fetch_req) n_req++;
    if (res_vld && res_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL res_unexpected: handshake with lane0 %h but no result expected", res[15:0]);
      end else begin
        logic [RW-1:0] e;
        int nd;
        e = exp_q.pop_front();
        nd = 0;
        for (int i = 0; i < NL; i++) if (res[16*i +: 16] !== e[16*i +: 16]) nd++;
        if (nd != 0) begin
          errors++;
          $display("FAIL res_data: lane0 got %h expected %h, %0d lanes differ", res[15:0], e[15:0], nd);
        end
      end
    end
  end

  // Entered and left at posedge+1; leaves the DUT one cycle after accept.
  task automatic accept(input logic [KT_W-1:0] kt);
    job_vld = 1'b1;
    job_kt  = kt;
    @(negedge clk);
    chk("job_rdy_idle", job_rdy, 1);
    chk("busy_idle", busy, 0);
    @(posedge clk); #1;
    job_vld = 1'b0;
    job_kt  = '0;
  endtask

  // One tile: fetch (optionally delayed), start, wait, array result.
  task automatic tile(input logic [15:0] v, input int ack_dly, input logic [KT_W-1:0] idx,
                      input bit stray, input bit abort);
    logic [XW-1:0] x;
    logic [WW-1:0] w;
    for (int i = 0; i < XW/32; i++) x[32*i +: 32] = $urandom;
    for (int i = 0; i < WW/32; i++) w[32*i +: 32] = $urandom;
    for (int d = 0; d < ack_dly; d++) begin
      if (stray && d == 0) begin
        sa_out_vld = 1'b1;
        sa_out     = splat(16'h1234);
      end
      @(negedge clk);
      chk("req_hold", fetch_req, 1);
      chk("idx_hold", fetch_idx, idx);
      @(posedge clk); #1;
      sa_out_vld = 1'b0;
      sa_out     = '0;
    end
    fetch_ack = 1'b1;
    fetch_x   = x;
    fetch_w   = w;
    @(negedge clk);
    chk("req", fetch_req, 1);
    chk("idx", fetch_idx, idx);
    chk("start_early", sa_start, 0);
    @(posedge clk); #1;
    fetch_ack = 1'b0;
    fetch_x   = '0;
    fetch_w   = '0;
    @(negedge clk);
    chk("start", sa_start, 1);
    chk("req_drop", fetch_req, 0);
    chk("sa_x", sa_x, x);
    chk("sa_w", sa_w == w, 1);
    @(posedge clk); #1;
    if (abort) begin
      rst = 1'b1;
      @(negedge clk);
      chk("job_rdy_in_rst", job_rdy, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    if (stray) begin
      fetch_ack = 1'b1;
      fetch_x   = ~x;
      fetch_w   = ~w;
      @(negedge clk);
      chk("start_once", sa_start, 0);
      @(posedge clk); #1;
      fetch_ack = 1'b0;
      fetch_x   = '0;
      fetch_w   = '0;
    end
    sa_out_vld = 1'b1;
    sa_out     = splat(v);
    @(negedge clk);
    chk("sa_x_stable", sa_x, x);
    chk("sa_w_stable", sa_w == w, 1);
    @(posedge clk); #1;
    sa_out_vld = 1'b0;
    sa_out     = '0;
  endtask

  task automatic finish_job(input int rdy_dly, input logic [RW-1:0] e);
    exp_q.push_back(e);
    for (int d = 0; d <= rdy_dly; d++) begin
      res_rdy = (d == rdy_dly);
      @(negedge clk);
      chk("res_vld", res_vld, 1);
      chk("res_stable", res == e, 1);
      chk("job_rdy_done", job_rdy, 0);
      chk("busy_done", busy, 1);
      @(posedge clk); #1;
    end
    res_rdy = 1'b0;
    @(negedge clk);
    chk("res_vld_drop", res_vld, 0);
    chk("job_rdy_after", job_rdy, 1);
    chk("busy_after", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int s_start;
    int s_req;
    rst = 1'b1; job_vld = 1'b0; job_kt = '0; fetch_ack = 1'b0; fetch_x = '0; fetch_w = '0;
    sa_out_vld = 1'b0; sa_out = '0; res_rdy = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_job_rdy", job_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", fetch_req, 0);
    chk("rst_idx", fetch_idx, 0);
    chk("rst_start", sa_start, 0);
    chk("rst_res_vld", res_vld, 0);
    chk("rst_res", res == '0, 1);
    chk("rst_sa_x", sa_x, 0);
    chk("rst_sa_w", sa_w == '0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("job_rdy_post_rst", job_rdy, 1);
    @(posedge clk); #1;

    // KT=2, 0x2000 + 0x2000
    s_start = n_start;
    accept(2);
    tile(16'h2000, 0, 0, 0, 0);
    tile(16'h2000, 0, 1, 0, 0);
    finish_job(0, splat(16'h4000));
    chk("start_count_kt2", n_start - s_start, 2);

    // KT=2 positive and negative overflow
    accept(2);
    tile(16'h6000, 0, 0, 0, 0);
    tile(16'h6000, 0, 1, 0, 0);
    finish_job(0, splat(EXP_POS));
    accept(2);
    tile(16'hA000, 0, 0, 0, 0);
    tile(16'hA000, 0, 1, 0, 0);
    finish_job(0, splat(EXP_NEG));

    // KT=3 signed mix: 0x2000 - 0x1000 + 0x0800
    accept(3);
    tile(16'h2000, 0, 0, 0, 0);
    tile(16'hF000, 0, 1, 0, 0);
    tile(16'h0800, 0, 2, 0, 0);
    finish_job(0, splat(16'h1800));

    // KT=0: immediate zero result, no fetch or start
    s_start = n_start;
    s_req   = n_req;
    accept(0);
    finish_job(0, '0);
    chk("kt0_no_start", n_start - s_start, 0);
    chk("kt0_no_req", n_req - s_req, 0);

    // KT=1 with slow ack and slow result ready
    accept(1);
    tile(16'h1357, 4, 0, 0, 0);
    finish_job(5, splat(16'h1357));

    // Stray array-valid in FETCH and stray ack in WAIT
    accept(2);
    tile(16'h0100, 0, 0, 0, 0);
    tile(16'h0200, 1, 1, 1, 0);
    finish_job(0, splat(16'h0300));

    // Reset during WAIT of tile 1, then a late array result
    accept(3);
    tile(16'h1000, 0, 0, 0, 0);
    tile(16'h2000, 0, 1, 0, 1);
    sa_out_vld = 1'b1;
    sa_out     = splat(16'h7777);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_req", fetch_req, 0);
    chk("abort_start", sa_start, 0);
    chk("abort_res_vld", res_vld, 0);
    chk("abort_res_clr", res == '0, 1);
    chk("abort_idx", fetch_idx, 0);
    chk("abort_job_rdy", job_rdy, 1);
    @(posedge clk); #1;
    sa_out_vld = 1'b0;
    sa_out     = '0;
    @(negedge clk);
    chk("late_vld_res", res == '0, 1);
    chk("late_vld_busy", busy, 0);
    @(posedge clk); #1;
    accept(1);
    tile(16'h1000, 0, 0, 0, 0);
    finish_job(0, splat(16'h1000));

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
